// File: rtl/irrigation_scheduler.sv
// Soil-moisture driven watering scheduler: averages sensor samples, issues a
// one-cycle duration request to the watering controller and tracks the job.
module irrigation_scheduler #(
  parameter int unsigned NUM_SAMPLES_LOG2 = 2,
  parameter logic [7:0]  DRY_THRESHOLD    = 8'd80,
  parameter logic [7:0]  MIN_TIME         = 8'd10,
  parameter int unsigned GAIN_SHIFT       = 1,
  parameter logic [7:0]  MAX_TIME         = 8'd120,
  parameter int unsigned START_TIMEOUT    = 4,
  parameter int unsigned HOLDOFF_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       auto_en,
  input  logic       fault_clr,
  input  logic [7:0] moisture_level,
  input  logic       moisture_valid,
  input  logic       sensor_enable,
  input  logic       watering_in_progress,
  output logic [7:0] irrigation_time,
  output logic       sample_req,
  output logic       busy,
  output logic [7:0] last_avg,
  output logic [7:0] request_count,
  output logic       fault
);

  localparam int unsigned ACC_W       = 8 + NUM_SAMPLES_LOG2;
  localparam int unsigned CNT_W       = NUM_SAMPLES_LOG2 + 1;
  localparam int unsigned NUM_SAMPLES = 1 << NUM_SAMPLES_LOG2;
  localparam int unsigned TMR_MAX     = (START_TIMEOUT > HOLDOFF_CYCLES) ? START_TIMEOUT : HOLDOFF_CYCLES;
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SAMPLE     = 3'd1;
  localparam logic [2:0] S_DECIDE     = 3'd2;
  localparam logic [2:0] S_REQUEST    = 3'd3;
  localparam logic [2:0] S_WAIT_START = 3'd4;
  localparam logic [2:0] S_WAIT_DONE  = 3'd5;
  localparam logic [2:0] S_HOLDOFF    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       irr_q, irr_d;
  logic [7:0]       last_avg_q, last_avg_d;
  logic [7:0]       req_cnt_q, req_cnt_d;
  logic             fault_q, fault_d;
  logic             sample_req_q, sample_req_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic [7:0]       avg_c;
  logic [15:0]      dur_raw_c;
  logic [15:0]      dur_c;

  assign accept_c = moisture_valid & sensor_enable;
  assign avg_c    = 8'(acc_q >> NUM_SAMPLES_LOG2);

  // Duration grows with the moisture deficit, saturated at MAX_TIME.
  always_comb begin
    dur_raw_c = 16'(MIN_TIME) + (16'(DRY_THRESHOLD - avg_c) << GAIN_SHIFT);
    dur_c     = (dur_raw_c > 16'(MAX_TIME)) ? 16'(MAX_TIME) : dur_raw_c;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    irr_d      = 8'd0;
    last_avg_d = last_avg_q;
    req_cnt_d  = req_cnt_q;
    fault_d    = fault_clr ? 1'b0 : fault_q;

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (auto_en) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (!auto_en) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (accept_c) begin
          acc_d = acc_q + ACC_W'(moisture_level);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_SAMPLES - 1)) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        last_avg_d = avg_c;
        acc_d      = '0;
        cnt_d      = '0;
        tmr_d      = '0;
        if (avg_c >= DRY_THRESHOLD) begin
          state_d = S_HOLDOFF;
        end else begin
          irr_d   = dur_c[7:0];
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        tmr_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (watering_in_progress) begin
          tmr_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (tmr_q == TMR_W'(START_TIMEOUT - 1)) begin
          // A timeout overrides a simultaneous fault_clr.
          fault_d = 1'b1;
          tmr_d   = '0;
          state_d = S_HOLDOFF;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!watering_in_progress) begin
          if (req_cnt_q != 8'hFF) req_cnt_d = req_cnt_q + 8'd1;
          tmr_d   = '0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (!auto_en) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else if (tmr_q == TMR_W'(HOLDOFF_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sample_req_d = (state_d == S_SAMPLE) & sensor_enable;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      irr_q        <= 8'd0;
      last_avg_q   <= 8'd0;
      req_cnt_q    <= 8'd0;
      fault_q      <= 1'b0;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      irr_q        <= irr_d;
      last_avg_q   <= last_avg_d;
      req_cnt_q    <= req_cnt_d;
      fault_q      <= fault_d;
      sample_req_q <= sample_req_d;
      busy_q       <= busy_d;
    end
  end

  assign irrigation_time = irr_q;
  assign sample_req      = sample_req_q;
  assign busy            = busy_q;
  assign last_avg        = last_avg_q;
  assign request_count   = req_cnt_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: directed scenarios followed by
// randomized rounds against a behavioural watering model.
module tb_irrigation_scheduler;

  localparam int DRY     = 80;
  localparam int MINT    = 10;
  localparam int MAXT    = 120;
  localparam int TIMEOUT = 4;
  localparam int HOLD    = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       auto_en;
  logic       fault_clr;
  logic [7:0] moisture_level;
  logic       moisture_valid;
  logic       sensor_enable;
  logic       watering_in_progress;
  logic [7:0] irrigation_time;
  logic       sample_req;
  logic       busy;
  logic [7:0] last_avg;
  logic [7:0] request_count;
  logic       fault;

  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_cycles = 0;
  int   pulse_overrun = 0;
  logic prev_nz = 1'b0;
  int   exp_pulses = 0;
  int   exp_count = 0;
  logic exp_fault = 1'b0;
  logic [7:0] smp [4];

  always #5 clk = ~clk;

  irrigation_scheduler dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .auto_en              (auto_en),
    .fault_clr            (fault_clr),
    .moisture_level       (moisture_level),
    .moisture_valid       (moisture_valid),
    .sensor_enable        (sensor_enable),
    .watering_in_progress (watering_in_progress),
    .irrigation_time      (irrigation_time),
    .sample_req           (sample_req),
    .busy                 (busy),
    .last_avg             (last_avg),
    .request_count        (request_count),
    .fault                (fault)
  );

  // Every request must be a single-cycle nonzero pulse.
  always @(negedge clk) begin
    if (irrigation_time != 8'd0) begin
      pulse_cycles++;
      if (prev_nz) pulse_overrun++;
    end
    prev_nz = (irrigation_time != 8'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_avg();
    int sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(smp[i]);
    return sum / 4;
  endfunction

  function automatic int model_dur(input int avg);
    int d;
    if (avg >= DRY) return 0;
    d = MINT + (DRY - avg) * 2;
    return (d > MAXT) ? MAXT : d;
  endfunction

  task automatic wait_sampling(input string tag, input int max_cyc, input int exp_cyc);
    int k = 0;
    do begin
      step();
      k++;
    end while (sample_req !== 1'b1 && k < max_cyc);
    check(tag, k, exp_cyc);
  endtask

  task automatic feed(input bit gate);
    for (int i = 0; i < 4; i++) begin
      if (gate) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          sensor_enable = 1'b0; moisture_valid = 1'b1; moisture_level = 8'($urandom);
          step();
        end
        if ($urandom_range(0, 1) == 1) begin
          sensor_enable = 1'b1; moisture_valid = 1'b0; moisture_level = 8'($urandom);
          step();
        end
      end
      sensor_enable = 1'b1; moisture_valid = 1'b1; moisture_level = smp[i];
      step();
    end
    moisture_valid = 1'b0;
    sensor_enable  = 1'b1;
  endtask

  task automatic wait_pulse();
    int k = 0;
    while (irrigation_time == 8'd0 && k < 6) begin
      step();
      k++;
    end
  endtask

  // One decision round starting in SAMPLE; mode 0 normal job, 1 start timeout,
  // 2 start timeout with fault_clr held through it.
  task automatic round(input string tag, input bit gate, input int mode, input int d, input int h);
    int avg;
    int dur;
    feed(gate);
    avg = model_avg();
    dur = model_dur(avg);
    if (dur == 0) begin
      step();
      check($sformatf("%s/wet_avg", tag), last_avg, avg);
      check($sformatf("%s/wet_no_req", tag), irrigation_time, 0);
      check($sformatf("%s/wet_busy", tag), busy, 1);
      wait_sampling($sformatf("%s/wet_holdoff", tag), 24, HOLD);
    end else begin
      wait_pulse();
      exp_pulses++;
      check($sformatf("%s/dur", tag), irrigation_time, dur);
      check($sformatf("%s/avg", tag), last_avg, avg);
      step();
      check($sformatf("%s/pulse_end", tag), irrigation_time, 0);
      if (mode == 0) begin
        repeat (d) step();
        watering_in_progress = 1'b1;
        step();
        repeat (h) step();
        watering_in_progress = 1'b0;
        step();
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        check($sformatf("%s/count", tag), request_count, exp_count);
        check($sformatf("%s/fault_kept", tag), fault, exp_fault);
      end else begin
        if (mode == 2) fault_clr = 1'b1;
        repeat (TIMEOUT - 1) step();
        check($sformatf("%s/fault_pre", tag), fault, (mode == 2) ? 1'b0 : exp_fault);
        step();
        fault_clr = 1'b0;
        exp_fault = 1'b1;
        check($sformatf("%s/fault_set", tag), fault, 1);
        check($sformatf("%s/count_kept", tag), request_count, exp_count);
      end
      wait_sampling($sformatf("%s/holdoff", tag), 24, HOLD);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s/irr", tag), irrigation_time, 0);
    check($sformatf("%s/sreq", tag), sample_req, 0);
    check($sformatf("%s/busy", tag), busy, 0);
    check($sformatf("%s/avg", tag), last_avg, 0);
    check($sformatf("%s/cnt", tag), request_count, 0);
    check($sformatf("%s/fault", tag), fault, 0);
  endtask

  initial begin
    reset_n = 1'b0; auto_en = 1'b0; fault_clr = 1'b0;
    moisture_level = 8'd0; moisture_valid = 1'b0; sensor_enable = 1'b1;
    watering_in_progress = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check("idle_no_auto", busy, 0);

    auto_en = 1'b1;
    wait_sampling("idle_to_sample", 4, 1);
    check("busy_sampling", busy, 1);

    smp = '{8'd60, 8'd60, 8'd60, 8'd60};
    round("req60", 1'b0, 0, 1, 3);
    smp = '{8'd100, 8'd100, 8'd100, 8'd100};
    round("wet100", 1'b0, 0, 0, 0);
    smp = '{8'd0, 8'd0, 8'd0, 8'd0};
    round("sat0", 1'b0, 0, 0, 2);
    smp = '{8'd79, 8'd79, 8'd79, 8'd79};
    round("min79", 1'b0, 0, 2, 1);
    smp = '{8'd20, 8'd21, 8'd22, 8'd23};
    round("gated", 1'b1, 0, 0, 4);
    smp = '{8'd40, 8'd41, 8'd42, 8'd43};
    round("late_start", 1'b0, 0, TIMEOUT - 1, 2);

    smp = '{8'd50, 8'd50, 8'd50, 8'd50};
    round("timeout", 1'b0, 1, 0, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    exp_fault = 1'b0;
    check("fault_clr", fault, 0);

    round("timeout2", 1'b0, 1, 0, 0);
    round("set_wins", 1'b0, 2, 0, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    exp_fault = 1'b0;
    check("fault_clr2", fault, 0);

    // Partial sum must be discarded when auto_en drops mid-round.
    for (int i = 0; i < 2; i++) begin
      moisture_valid = 1'b1; moisture_level = 8'd0;
      step();
    end
    moisture_valid = 1'b0;
    auto_en = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_sreq", sample_req, 0);
    auto_en = 1'b1;
    wait_sampling("restart", 4, 1);
    smp = '{8'd70, 8'd70, 8'd70, 8'd70};
    round("after_abort", 1'b0, 0, 0, 1);

    smp = '{8'd200, 8'd200, 8'd200, 8'd200};
    feed(1'b0);
    step();
    check("holdoff_avg", last_avg, 200);
    repeat (5) step();
    auto_en = 1'b0;
    step();
    check("holdoff_abort", busy, 0);
    auto_en = 1'b1;
    wait_sampling("restart2", 4, 1);

    for (int r = 0; r < 25; r++) begin
      int sel = $urandom_range(0, 5);
      int mode = (sel == 0) ? 1 : ((sel == 1) ? 2 : 0);
      int hi = ($urandom_range(0, 1) == 1) ? 90 : 255;
      for (int i = 0; i < 4; i++) smp[i] = 8'($urandom_range(0, hi));
      round($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), mode,
            $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 8));
    end

    // Asynchronous reset while a job is in flight.
    smp = '{8'd30, 8'd30, 8'd30, 8'd30};
    feed(1'b0);
    wait_pulse();
    exp_pulses++;
    check("rst_job_dur", irrigation_time, 110);
    step();
    watering_in_progress = 1'b1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    watering_in_progress = 1'b0;
    exp_count = 0;
    exp_fault = 1'b0;
    step();
    reset_n = 1'b1;
    wait_sampling("rst_restart", 4, 1);
    check("rst_busy", busy, 1);
    smp = '{8'd90, 8'd10, 8'd50, 8'd70};
    round("post_rst", 1'b0, 0, 1, 2);

    check("pulse_cycles", pulse_cycles, exp_pulses);
    check("pulse_single", pulse_overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
